l2_cache_wb: RTL

Parametrised write-back, write-allocate, N-way set-associative L2 cache between the L1 cache and main memory. It generalises the earlier read-allocate L2 with per-line dirty bits and dirty-victim write-back. It also adds deterministic replacement (first invalid way, else per-set round-robin) and word-granular L1 writes merged into resident or refilled blocks. The L1 side and the memory side both transfer whole blocks; the L1 side also carries single-word write data.

---
 rtl/l2_cache_pkg.sv | 41 ++++
 rtl/l2_cache_wb_if.sv | 36 +++
 rtl/l2_victim_sel.sv | 24 ++
 rtl/l2_cache_wb.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/l2_cache_pkg.sv
// Shared types and geometry helpers for the write-back L2 cache.
// The top module derives its field widths from these functions.
package l2_cache_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StWriteback,
    StRefill,
    StRespond
  } state_e;

  function automatic int unsigned calc_wpb(int unsigned block_size, int unsigned data_width);
    return block_size / (data_width / 8);
  endfunction

  function automatic int unsigned calc_sets(int unsigned cache_size, int unsigned block_size,
                                            int unsigned num_ways);
    return cache_size / block_size / num_ways;
  endfunction

  function automatic int unsigned calc_off(int unsigned block_size);
    return $clog2(block_size);
  endfunction

  function automatic int unsigned calc_idx(int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned calc_tag(int unsigned addr_width, int unsigned idx_bits,
                                           int unsigned off_bits);
    return addr_width - idx_bits - off_bits;
  endfunction

  // Block-aligned byte address built from a tag and a set index.
  function automatic logic [31:0] line_addr(logic [31:0] tag, logic [31:0] idx,
                                            int unsigned idx_bits, int unsigned off_bits);
    return (tag << (idx_bits + off_bits)) | (idx << off_bits);
  endfunction

endpackage

// File: rtl/l2_cache_wb_if.sv
// L1-side and memory-side bus of the write-back L2 cache.
// The cache attaches through the slave modport; its environment through master.
interface l2_cache_wb_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned BLK        = 256
);
  logic                  l1_req_valid;
  logic                  l1_req_write;
  logic [ADDR_WIDTH-1:0] l1_req_addr;
  logic [DATA_WIDTH-1:0] l1_req_wdata;
  logic                  l1_req_ready;
  logic                  l1_resp_valid;
  logic                  l1_resp_hit;
  logic [BLK-1:0]        l1_resp_block;
  logic                  mem_req_valid;
  logic                  mem_req_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [BLK-1:0]        mem_wblock;
  logic [BLK-1:0]        mem_rblock;
  logic                  mem_ready;

  modport master (
    output l1_req_valid, l1_req_write, l1_req_addr, l1_req_wdata,
    input  l1_req_ready, l1_resp_valid, l1_resp_hit, l1_resp_block,
    input  mem_req_valid, mem_req_write, mem_addr, mem_wblock,
    output mem_rblock, mem_ready
  );

  modport slave (
    input  l1_req_valid, l1_req_write, l1_req_addr, l1_req_wdata,
    output l1_req_ready, l1_resp_valid, l1_resp_hit, l1_resp_block,
    output mem_req_valid, mem_req_write, mem_addr, mem_wblock,
    input  mem_rblock, mem_ready
  );
endinterface

// File: rtl/l2_victim_sel.sv
// Replacement choice for one set: lowest invalid way, otherwise the round-robin way.
// rr_advance tells the parent to bump that set's pointer.
module l2_victim_sel
  import l2_cache_pkg::*;
#(
  parameter  int unsigned NUM_WAYS = 4,
  localparam int unsigned WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0] valid,
  input  logic [WAY_W-1:0]    rr_ptr,
  output logic [WAY_W-1:0]    victim_way,
  output logic                rr_advance
);

  always_comb begin
    victim_way = rr_ptr;
    rr_advance = &valid;
    // Descending scan so the lowest invalid way wins.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) victim_way = WAY_W'(w);
    end
  end

endmodule

// File: rtl/l2_cache_wb.sv
// Write-back, write-allocate, N-way set-associative L2 cache.
// One transaction at a time: lookup, optional dirty write-back, refill, respond.
module l2_cache_wb
  import l2_cache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned CACHE_SIZE = 512,
  parameter int unsigned BLOCK_SIZE = 32,
  parameter int unsigned NUM_WAYS   = 4
) (
  input logic       clk,
  input logic       rst,
  l2_cache_wb_if.slave bus
);

  localparam int unsigned WPB      = calc_wpb(BLOCK_SIZE, DATA_WIDTH);
  localparam int unsigned SETS     = calc_sets(CACHE_SIZE, BLOCK_SIZE, NUM_WAYS);
  localparam int unsigned OFF      = calc_off(BLOCK_SIZE);
  localparam int unsigned IDX      = calc_idx(SETS);
  localparam int unsigned TAG      = calc_tag(ADDR_WIDTH, IDX, OFF);
  localparam int unsigned BLK      = DATA_WIDTH * WPB;
  localparam int unsigned WAY_W    = $clog2(NUM_WAYS);
  localparam int unsigned WORD_LSB = $clog2(DATA_WIDTH / 8);
  localparam int unsigned WORD_W   = OFF - WORD_LSB;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:WORD_LSB] addr_q;
  logic                         write_q;
  logic [DATA_WIDTH-1:0]        wdata_q;
  logic [NUM_WAYS-1:0]          valid_q [SETS];
  logic [NUM_WAYS-1:0]          dirty_q [SETS];
  logic [WAY_W-1:0]             rr_q    [SETS];
  logic [TAG-1:0]               tag_q   [SETS][NUM_WAYS];
  logic [BLK-1:0]               data_q  [SETS][NUM_WAYS];
  logic [WAY_W-1:0]             way_q;
  logic                         hit_q;
  logic [BLK-1:0]               line_q;
  logic [TAG-1:0]               vtag_q;

  logic [TAG-1:0]    req_tag;
  logic [IDX-1:0]    req_idx;
  logic [WORD_W-1:0] req_word;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  victim_way;
  logic              rr_advance;
  logic              victim_dirty;
  logic [BLK-1:0]    hit_line;
  logic [BLK-1:0]    fill_line;

  assign req_tag  = addr_q[ADDR_WIDTH-1 -: TAG];
  assign req_idx  = addr_q[OFF +: IDX];
  assign req_word = addr_q[WORD_LSB +: WORD_W];

  function automatic logic [BLK-1:0] merge_word(logic [BLK-1:0] line, logic [WORD_W-1:0] word,
                                                logic [DATA_WIDTH-1:0] data);
    logic [BLK-1:0] res;
    res = line;
    res[word*DATA_WIDTH +: DATA_WIDTH] = data;
    return res;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  l2_victim_sel #(
    .NUM_WAYS(NUM_WAYS)
  ) u_victim_sel (
    .valid     (valid_q[req_idx]),
    .rr_ptr    (rr_q[req_idx]),
    .victim_way(victim_way),
    .rr_advance(rr_advance)
  );

  assign victim_dirty = valid_q[req_idx][victim_way] & dirty_q[req_idx][victim_way];
  assign hit_line  = write_q ? merge_word(data_q[req_idx][hit_way], req_word, wdata_q)
                             : data_q[req_idx][hit_way];
  assign fill_line = write_q ? merge_word(bus.mem_rblock, req_word, wdata_q) : bus.mem_rblock;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (bus.l1_req_valid) state_d = StLookup;
      StLookup:    state_d = hit ? StRespond : (victim_dirty ? StWriteback : StRefill);
      StWriteback: if (bus.mem_ready) state_d = StRefill;
      StRefill:    if (bus.mem_ready) state_d = StRespond;
      StRespond:   state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // rst gates ready so every output reads 0 while reset is held.
  always_comb begin
    bus.l1_req_ready  = (state_q == StIdle) && !rst;
    bus.l1_resp_valid = (state_q == StRespond);
    bus.l1_resp_hit   = (state_q == StRespond) && hit_q;
    bus.l1_resp_block = (state_q == StRespond) ? line_q : '0;
    bus.mem_req_valid = (state_q == StWriteback) || (state_q == StRefill);
    bus.mem_req_write = (state_q == StWriteback);
    bus.mem_addr      = '0;
    bus.mem_wblock    = '0;
    if (state_q == StWriteback) begin
      bus.mem_addr   = ADDR_WIDTH'(line_addr(32'(vtag_q), 32'(req_idx), IDX, OFF));
      bus.mem_wblock = line_q;
    end else if (state_q == StRefill) begin
      bus.mem_addr = ADDR_WIDTH'(line_addr(32'(req_tag), 32'(req_idx), IDX, OFF));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      valid_q <= '{default: '0};
      dirty_q <= '{default: '0};
      rr_q    <= '{default: '0};
      way_q   <= '0;
      hit_q   <= 1'b0;
      line_q  <= '0;
      vtag_q  <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (bus.l1_req_valid) begin
            addr_q  <= bus.l1_req_addr[ADDR_WIDTH-1:WORD_LSB];
            write_q <= bus.l1_req_write;
            wdata_q <= bus.l1_req_wdata;
          end
        end
        StLookup: begin
          hit_q <= hit;
          if (hit) begin
            way_q  <= hit_way;
            line_q <= hit_line;
            if (write_q) dirty_q[req_idx][hit_way] <= 1'b1;
          end else begin
            // line_q carries the victim line through WRITEBACK.
            way_q  <= victim_way;
            vtag_q <= tag_q[req_idx][victim_way];
            line_q <= data_q[req_idx][victim_way];
            if (rr_advance) rr_q[req_idx] <= rr_q[req_idx] + WAY_W'(1);
          end
        end
        StWriteback: begin
          if (bus.mem_ready) dirty_q[req_idx][way_q] <= 1'b0;
        end
        StRefill: begin
          if (bus.mem_ready) begin
            valid_q[req_idx][way_q] <= 1'b1;
            dirty_q[req_idx][way_q] <= write_q;
            line_q                  <= fill_line;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays need no reset: valid bits qualify them.
  always_ff @(posedge clk) begin
    if (state_q == StLookup && hit && write_q) begin
      data_q[req_idx][hit_way] <= hit_line;
    end
    if (state_q == StRefill && bus.mem_ready) begin
      data_q[req_idx][way_q] <= fill_line;
      tag_q[req_idx][way_q]  <= req_tag;
    end
  end

endmodule
